// File: rtl/arb_mux.sv
// N-way registered mux with valid/ready on every channel.
// Picks one channel per cycle by external select or round-robin.
module arb_mux #(
    parameter int WIDTH    = 64,
    parameter int N        = 4,
    parameter int ARB_MODE = 0,
    localparam int SELW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             can_accept;
    logic [N-1:0]     grant;
    logic             xfer;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    assign can_accept = !out_valid_q || out_ready;

    always_comb begin : arbitrate
        int   target;
        logic found;
        grant  = '0;
        target = 0;
        found  = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i)) begin
                    grant[i] = in_valid[i];
                end
            end
        end else begin
            // search upward from the channel after the last winner
            for (int k = 1; k <= N; k++) begin
                target = int'(ptr_q) + k;
                if (target >= N) begin
                    target = target - N;
                end
                for (int i = 0; i < N; i++) begin
                    if (!found && (i == target) && in_valid[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : encode
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gnt_idx  = SELW'(i);
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (reset || !can_accept) ? '0 : grant;
    assign xfer     = |in_ready;

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_src_d   = gnt_idx;
            out_valid_d = 1'b1;
            if (ARB_MODE != 0) begin
                ptr_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: select N=4, round-robin N=4, select N=3,
// directed cases plus random traffic against a behavioural model.
module tb_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [255:0] in_data;
    logic [3:0]   in_valid;
    logic [1:0]   sel;
    logic         out_ready;

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic [63:0] od0, od1, od2;
    logic        ov0, ov1, ov2;
    logic [1:0]  os0, os1, os2;

    arb_mux #(.WIDTH(64), .N(4), .ARB_MODE(0)) u_sel4 (
        .clk(clk), .reset(reset), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy0), .sel(sel),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .out_src(os0)
    );

    arb_mux #(.WIDTH(64), .N(4), .ARB_MODE(1)) u_rr4 (
        .clk(clk), .reset(reset), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy1), .sel(sel),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .out_src(os1)
    );

    arb_mux #(.WIDTH(64), .N(3), .ARB_MODE(0)) u_sel3 (
        .clk(clk), .reset(reset), .in_data(in_data[191:0]),
        .in_valid(in_valid[2:0]), .in_ready(rdy2), .sel(sel),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
        .out_src(os2)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    logic [3:0]  d_rdy [3];
    logic [63:0] d_od  [3];
    logic        d_ov  [3];
    logic [1:0]  d_os  [3];
    assign d_rdy[0] = rdy0;
    assign d_rdy[1] = rdy1;
    assign d_rdy[2] = {1'b0, rdy2};
    assign d_od[0] = od0;
    assign d_od[1] = od1;
    assign d_od[2] = od2;
    assign d_ov[0] = ov0;
    assign d_ov[1] = ov1;
    assign d_ov[2] = ov2;
    assign d_os[0] = os0;
    assign d_os[1] = os1;
    assign d_os[2] = os2;

    int n_of[3]    = '{4, 4, 3};
    int mode_of[3] = '{0, 1, 0};

    logic        m_ov  [3];
    logic [63:0] m_od  [3];
    int          m_os  [3];
    int          m_ptr [3];
    bit          started = 1'b0;

    // Model state holds what the outputs must be after the last edge;
    // it is advanced here using the inputs that the next edge will see.
    always @(negedge clk) begin
        int   g, n, idx;
        logic can;
        logic [3:0] exp_rdy;
        for (int k = 0; k < 3; k++) begin
            n = n_of[k];
            if (started) begin
                chk($sformatf("i%0d out_valid", k), 64'(d_ov[k]), 64'(m_ov[k]));
                chk($sformatf("i%0d out_data", k), d_od[k], m_od[k]);
                chk($sformatf("i%0d out_src", k), 64'(d_os[k]), 64'(m_os[k]));
            end
            g = -1;
            if (!reset) begin
                can = !m_ov[k] || out_ready;
                if (mode_of[k] == 0) begin
                    if (int'(sel) < n && in_valid[sel]) g = int'(sel);
                end else begin
                    for (int j = 1; j <= n; j++) begin
                        idx = (m_ptr[k] + j) % n;
                        if (g < 0 && in_valid[idx]) g = idx;
                    end
                end
                if (!can) g = -1;
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
            if (started || reset)
                chk($sformatf("i%0d in_ready", k), 64'(d_rdy[k]), 64'(exp_rdy));
            if (reset) begin
                m_ov[k]  = 1'b0;
                m_od[k]  = '0;
                m_os[k]  = 0;
                m_ptr[k] = n - 1;
            end else if (g >= 0) begin
                m_ov[k] = 1'b1;
                m_od[k] = in_data[g*64 +: 64];
                m_os[k] = g;
                if (mode_of[k] == 1) m_ptr[k] = g;
            end else if (out_ready) begin
                m_ov[k] = 1'b0;
            end
        end
        if (reset) started = 1'b1;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int base);
        for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = 64'(base + i);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        sel       = '0;
        out_ready = 1'b1;
        in_data   = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(ov0), 64'd0);
        chk("reset out_data", od1, 64'd0);
        chk("reset out_src", 64'(os1), 64'd0);
        chk("reset in_ready", 64'(rdy1), 64'd0);

        // invalid select on the N=3 instance
        nxt();
        reset = 1'b0;
        sel = 2'd3;
        in_valid = 4'b1111;
        set_ch('h1000);
        @(negedge clk);
        chk("badsel in_ready", 64'(rdy2), 64'd0);
        chk("sel3 in_ready", 64'(rdy0), 64'b1000);
        chk("rr first in_ready", 64'(rdy1), 64'b0001);
        nxt();
        @(negedge clk);
        chk("badsel out_valid", 64'(ov2), 64'd0);
        chk("sel3 out_src", 64'(os0), 64'd3);

        // select mode basic transfer
        nxt();
        sel = 2'd2;
        in_valid = 4'b0100;
        in_data[2*64 +: 64] = 64'hDEAD_BEEF_0000_0002;
        @(negedge clk);
        chk("basic in_ready", 64'(rdy0), 64'b0100);
        nxt();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("basic out_valid", 64'(ov0), 64'd1);
        chk("basic out_data", od0, 64'hDEAD_BEEF_0000_0002);
        chk("basic out_src", 64'(os0), 64'd2);

        // backpressure hold
        nxt();
        sel = 2'd1;
        in_valid = 4'b1111;
        set_ch('hA0);
        nxt();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp in_ready", 64'(rdy0), 64'd0);
            chk("bp out_data", od0, 64'hA1);
            chk("bp out_src", 64'(os0), 64'd1);
            nxt();
        end
        out_ready = 1'b1;
        in_data[64 +: 64] = 64'hB1;
        @(negedge clk);
        chk("bp resume in_ready", 64'(rdy0), 64'b0010);
        nxt();
        @(negedge clk);
        chk("bp next out_data", od0, 64'hB1);
        chk("bp next out_valid", 64'(ov0), 64'd1);

        // reset while stalled with a word held
        nxt();
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst cycle in_ready", 64'(rdy0), 64'd0);
        nxt();
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 4'b1111;
        set_ch(0);
        @(negedge clk);
        chk("post rst out_valid", 64'(ov1), 64'd0);
        chk("post rst out_data", od1, 64'd0);
        chk("post rst out_src", 64'(os1), 64'd0);
        chk("post rst in_ready", 64'(rdy1), 64'b0001);

        // round-robin fairness
        for (int j = 0; j < 6; j++) begin
            nxt();
            @(negedge clk);
            chk("rr fair src", 64'(os1), 64'(j % 4));
            chk("rr fair data", od1, 64'(j % 4));
            chk("rr fair valid", 64'(ov1), 64'd1);
        end

        // sparse round-robin with skip and wrap
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        in_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            nxt();
            if (j == 3) in_valid = 4'b0001;
            @(negedge clk);
            chk("rr sparse src", 64'(os1), (j % 2 == 1) ? 64'd3 : 64'd1);
        end
        nxt();
        @(negedge clk);
        chk("rr wrap src", 64'(os1), 64'd0);

        // random traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            nxt();
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++)
                in_data[i*64 +: 64] = {$urandom, $urandom};
        end
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
